// File: rtl/reaction_bcd_timer_if.sv
// Control and display bundle between the button/display side and the reaction timer.
// The master drives the button pulses; the timer (slave) returns the registered display state.
interface reaction_bcd_timer_if;
   logic       start;
   logic       react;
   logic       stim_led;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic       result_valid;
   logic       foul;
   logic       overflow;
   logic       busy;

   modport master (
      output start, react,
      input  stim_led, digit0, digit1, digit2, digit3, result_valid, foul, overflow, busy
   );

   modport slave (
      input  start, react,
      output stim_led, digit0, digit1, digit2, digit3, result_valid, foul, overflow, busy
   );
endinterface

// File: rtl/reaction_bcd_timer.sv
// Reaction-time meter: random pre-delay, stimulus lamp, then millisecond count in 4-digit
// BCD until the player reacts. A press during the pre-delay is a foul.
module reaction_bcd_timer #(
   parameter int unsigned TICK_DIV        = 50000,
   parameter int unsigned DELAY_BASE_MS   = 1000,
   parameter int unsigned DELAY_SPAN_BITS = 11
) (
   input logic                 cin,
   input logic                 rst_n,
   reaction_bcd_timer_if.slave tmr
);

   localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DelayW = $clog2(DELAY_BASE_MS + (1 << DELAY_SPAN_BITS));
   localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

   typedef enum logic [2:0] {StIdle, StDelay, StCount, StDone, StFoul} state_e;

   state_e            state_q;
   logic [15:0]       lfsr_q;
   logic [TickW-1:0]  tick_cnt_q;
   logic [DelayW-1:0] delay_ms_q;
   logic [15:0]       digits_q;
   logic              stim_q;
   logic              valid_q;
   logic              foul_q;
   logic              ovf_q;
   logic              busy_q;

   logic              tick;
   logic [15:0]       digits_inc;
   logic              carry;

   assign tick = ((state_q == StDelay) || (state_q == StCount)) && (tick_cnt_q == TickLast);

   // Ripple BCD increment; 9999 is never incremented because COUNT exits on reaching it.
   always_comb begin
      digits_inc = digits_q;
      carry      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (digits_q[4*i +: 4] == 4'd9) begin
               digits_inc[4*i +: 4] = 4'd0;
            end else begin
               digits_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
               carry                = 1'b0;
            end
         end
      end
   end

   // Fibonacci LFSR, taps 16,14,13,11, free-running so the delay depends on press timing.
   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end
   end

   always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         delay_ms_q <= '0;
         digits_q   <= '0;
         stim_q     <= 1'b0;
         valid_q    <= 1'b0;
         foul_q     <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone, StFoul: begin
               tick_cnt_q <= '0;
               if (tmr.start) begin
                  state_q    <= StDelay;
                  delay_ms_q <= DelayW'(DELAY_BASE_MS) + DelayW'(lfsr_q[DELAY_SPAN_BITS-1:0]);
                  digits_q   <= '0;
                  valid_q    <= 1'b0;
                  foul_q     <= 1'b0;
                  ovf_q      <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StDelay: begin
               tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
               if (tmr.react) begin
                  state_q    <= StFoul;
                  tick_cnt_q <= '0;
                  foul_q     <= 1'b1;
                  busy_q     <= 1'b0;
               end else if (tick) begin
                  if (delay_ms_q == DelayW'(1)) begin
                     state_q <= StCount;
                     stim_q  <= 1'b1;
                  end else begin
                     delay_ms_q <= delay_ms_q - DelayW'(1);
                  end
               end
            end
            StCount: begin
               tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
               // React takes priority over a coincident tick, freezing the pre-tick value.
               if (tmr.react) begin
                  state_q    <= StDone;
                  tick_cnt_q <= '0;
                  valid_q    <= 1'b1;
                  stim_q     <= 1'b0;
                  busy_q     <= 1'b0;
               end else if (tick) begin
                  digits_q <= digits_inc;
                  if (digits_inc == 16'h9999) begin
                     state_q    <= StDone;
                     tick_cnt_q <= '0;
                     valid_q    <= 1'b1;
                     ovf_q      <= 1'b1;
                     stim_q     <= 1'b0;
                     busy_q     <= 1'b0;
                  end
               end
            end
            default: begin
               state_q    <= StIdle;
               tick_cnt_q <= '0;
            end
         endcase
      end
   end

   assign tmr.stim_led     = stim_q;
   assign tmr.digit0       = digits_q[3:0];
   assign tmr.digit1       = digits_q[7:4];
   assign tmr.digit2       = digits_q[11:8];
   assign tmr.digit3       = digits_q[15:12];
   assign tmr.result_valid = valid_q;
   assign tmr.foul         = foul_q;
   assign tmr.overflow     = ovf_q;
   assign tmr.busy         = busy_q;

endmodule
